// File: rtl/serdesphy_rx_manchester_framer.sv
// RX Manchester decoder and byte framer: pair-phase hunt, sync-word
// alignment, one-entry valid/ready output register and error status.
module serdesphy_rx_manchester_framer #(
  parameter logic [7:0]  SYNC_WORD  = 8'hBC,
  parameter int unsigned VIOL_LIMIT = 4
) (
  input  logic       clk_240m_rx,
  input  logic       rst_240m_rx,
  input  logic       rx_en,
  input  logic       rx_serial_data,
  input  logic       rx_serial_valid,
  output logic [7:0] rx_word,
  output logic       rx_word_valid,
  input  logic       rx_word_ready,
  output logic       rx_locked,
  output logic       rx_code_viol,
  output logic [7:0] rx_viol_count,
  output logic       rx_overflow,
  output logic       rx_lock_lost,
  input  logic       rx_err_clr
);

  typedef enum logic [1:0] {
    DISABLED,
    HUNT,
    LOCKED
  } state_t;

  localparam logic [3:0] VLIM = 4'(VIOL_LIMIT);

  state_t     state;
  logic       phase;
  logic       first_chip;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [3:0] err_cnt;
  logic       byte_bad;

  logic       pair_done;
  logic       pair_ok;
  logic       dbit;
  logic [7:0] sr_next;
  logic       bad_next;
  logic [3:0] err_inc;
  logic       can_load;
  logic       active;

  assign active    = rx_en && (state != DISABLED);
  assign pair_done = rx_serial_valid && phase;
  assign pair_ok   = first_chip ^ rx_serial_data;
  // An invalid pair decodes as a 0 bit.
  assign dbit      = first_chip & pair_ok;
  assign sr_next   = {sr[6:0], dbit};
  assign bad_next  = byte_bad | ~pair_ok;
  assign err_inc   = err_cnt + 4'd1;
  assign can_load  = ~rx_word_valid | rx_word_ready;
  assign rx_locked = (state == LOCKED);

  always_ff @(posedge clk_240m_rx or posedge rst_240m_rx) begin
    if (rst_240m_rx) begin
      state         <= DISABLED;
      phase         <= 1'b0;
      first_chip    <= 1'b0;
      sr            <= '0;
      bit_cnt       <= '0;
      err_cnt       <= '0;
      byte_bad      <= 1'b0;
      rx_word       <= '0;
      rx_word_valid <= 1'b0;
      rx_code_viol  <= 1'b0;
      rx_viol_count <= '0;
      rx_overflow   <= 1'b0;
      rx_lock_lost  <= 1'b0;
    end else begin
      rx_code_viol <= 1'b0;

      if (rx_word_valid && rx_word_ready)
        rx_word_valid <= 1'b0;

      if (active && pair_done && !pair_ok) begin
        rx_code_viol <= 1'b1;
        if (rx_viol_count != 8'hFF)
          rx_viol_count <= rx_viol_count + 8'd1;
      end

      if (!rx_en) begin
        state      <= DISABLED;
        phase      <= 1'b0;
        first_chip <= 1'b0;
        sr         <= '0;
        bit_cnt    <= '0;
        err_cnt    <= '0;
        byte_bad   <= 1'b0;
      end else begin
        unique case (state)
          DISABLED: state <= HUNT;
          HUNT: begin
            if (rx_serial_valid) begin
              if (!phase) begin
                first_chip <= rx_serial_data;
                phase      <= 1'b1;
              end else if (!pair_ok) begin
                // Slip one chip: this second chip opens the next pair.
                first_chip <= rx_serial_data;
              end else begin
                phase <= 1'b0;
                sr    <= sr_next;
                if (sr_next == SYNC_WORD) begin
                  state    <= LOCKED;
                  bit_cnt  <= '0;
                  byte_bad <= 1'b0;
                  err_cnt  <= '0;
                end
              end
            end
          end
          LOCKED: begin
            if (rx_serial_valid) begin
              if (!phase) begin
                first_chip <= rx_serial_data;
                phase      <= 1'b1;
              end else begin
                phase <= 1'b0;
                sr    <= sr_next;
                if (bit_cnt == 3'd7) begin
                  bit_cnt  <= '0;
                  byte_bad <= 1'b0;
                  if (can_load) begin
                    rx_word       <= sr_next;
                    rx_word_valid <= 1'b1;
                  end else begin
                    rx_overflow <= 1'b1;
                  end
                  if (bad_next) begin
                    if (err_inc == VLIM) begin
                      state        <= HUNT;
                      rx_lock_lost <= 1'b1;
                      err_cnt      <= '0;
                    end else begin
                      err_cnt <= err_inc;
                    end
                  end else begin
                    err_cnt <= '0;
                  end
                end else begin
                  bit_cnt  <= bit_cnt + 3'd1;
                  byte_bad <= bad_next;
                end
              end
            end
          end
          default: state <= DISABLED;
        endcase
      end

      if (rx_err_clr) begin
        rx_overflow   <= 1'b0;
        rx_lock_lost  <= 1'b0;
        rx_viol_count <= '0;
      end
    end
  end

endmodule
